// File: rtl/multicycle_control_if.sv
// Control bus between the multicycle MIPS main control FSM and its datapath.
// master: the control FSM (drives enables/selects, sees opcode and mem_ready).
// slave:  the datapath side (drives opcode and mem_ready, sees the controls).
interface multicycle_control_if;
  logic [5:0] opcode;
  logic       mem_ready;

  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       MemtoReg;
  logic       IRWrite;
  logic       ALUSrcA;
  logic       RegWrite;
  logic       RegDst;
  logic       ZeroExt;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] PCSource;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  opcode, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
           ALUSrcA, RegWrite, RegDst, ZeroExt, ALUSrcB, ALUOp, PCSource,
           illegal_op, state
  );

  modport slave (
    output opcode, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
           ALUSrcA, RegWrite, RegDst, ZeroExt, ALUSrcB, ALUOp, PCSource,
           illegal_op, state
  );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath.
// Sequences fetch/decode/execute/memory/write-back and drives every datapath
// enable and select. Fetch and data-memory accesses stall on mem_ready.
// Optional feature macro: MC_ORI_EN -- makes opcode 001101 (ori) legal.
// The state register is the only storage; all outputs decode combinationally
// from the state (plus opcode/mem_ready where needed) and are held at 0 while
// reset is asserted.
module multicycle_control (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_RWB      = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_IMMEX    = 4'd10,
    S_IMMWB    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  state_t state_q;
  state_t state_d;
  logic   ori_op;
  logic   legal_op;

`ifdef MC_ORI_EN
  localparam logic [5:0] OP_ORI = 6'b001101;
  assign ori_op = (bus.opcode == OP_ORI);
`else
  assign ori_op = 1'b0;
`endif

  assign legal_op = (bus.opcode == OP_RTYPE) || (bus.opcode == OP_LW) ||
                    (bus.opcode == OP_SW)    || (bus.opcode == OP_BEQ) ||
                    (bus.opcode == OP_J)     || (bus.opcode == OP_ADDI) ||
                    ori_op;

  // State register: asynchronous reset straight back to FETCH.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value, independent of block evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state decode; unused codes 12-15 fall back to FETCH.
  always_comb begin
    // NOTE: a default before the case keeps every path assigned, so no latch
    // is inferred for state_d.
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (bus.opcode == OP_RTYPE)                          state_d = S_EXECUTE;
        else if (bus.opcode == OP_LW || bus.opcode == OP_SW) state_d = S_MEMADR;
        else if (bus.opcode == OP_BEQ)                       state_d = S_BRANCH;
        else if (bus.opcode == OP_J)                         state_d = S_JUMP;
        else if (bus.opcode == OP_ADDI || ori_op)            state_d = S_IMMEX;
        else                                                 state_d = S_FETCH;
      end
      S_MEMADR: begin
        if (bus.opcode == OP_LW)      state_d = S_MEMREAD;
        else if (bus.opcode == OP_SW) state_d = S_MEMWRITE;
        else                          state_d = S_FETCH;
      end
      S_MEMREAD:  state_d = bus.mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = bus.mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECUTE:  state_d = S_RWB;
      S_RWB:      state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JUMP:     state_d = S_FETCH;
      S_IMMEX:    state_d = S_IMMWB;
      S_IMMWB:    state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // Per-state output decode; everything is 0 unless the state drives it, and
  // reset forces all outputs low in the same cycle it is asserted.
  always_comb begin
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.IorD        = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.MemtoReg    = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.RegDst      = 1'b0;
    bus.ZeroExt     = 1'b0;
    bus.ALUSrcB     = 2'b00;
    bus.ALUOp       = 2'b00;
    bus.PCSource    = 2'b00;
    bus.illegal_op  = 1'b0;
    bus.state       = state_q;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          bus.MemRead = 1'b1;
          bus.ALUSrcB = 2'b01;
          bus.IRWrite = bus.mem_ready;
          bus.PCWrite = bus.mem_ready;
        end
        S_DECODE: begin
          bus.ALUSrcB    = 2'b11;
          bus.illegal_op = ~legal_op;
        end
        S_MEMADR: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUSrcB = 2'b10;
        end
        S_MEMREAD: begin
          bus.MemRead = 1'b1;
          bus.IorD    = 1'b1;
        end
        S_MEMWB: begin
          bus.RegWrite = 1'b1;
          bus.MemtoReg = 1'b1;
        end
        S_MEMWRITE: begin
          bus.MemWrite = 1'b1;
          bus.IorD     = 1'b1;
        end
        S_EXECUTE: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUOp   = 2'b10;
        end
        S_RWB: begin
          bus.RegWrite = 1'b1;
          bus.RegDst   = 1'b1;
        end
        S_BRANCH: begin
          bus.ALUSrcA     = 1'b1;
          bus.ALUOp       = 2'b01;
          bus.PCWriteCond = 1'b1;
          bus.PCSource    = 2'b01;
        end
        S_JUMP: begin
          bus.PCWrite  = 1'b1;
          bus.PCSource = 2'b10;
        end
        S_IMMEX: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUSrcB = 2'b10;
`ifdef MC_ORI_EN
          if (ori_op) begin
            bus.ALUOp   = 2'b11;
            bus.ZeroExt = 1'b1;
          end
`endif
        end
        S_IMMWB: begin
          bus.RegWrite = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed testbench for multicycle_control.
// Each step advances one clock, then checks the state code and the full packed
// output vector against hand-computed constants.
// Honours MC_ORI_EN the same way the design does.
module tb_multicycle_control;

  logic clk;
  logic reset;

  multicycle_control_if bus ();

  multicycle_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view of the outputs:
  // PCWrite PCWriteCond IorD MemRead MemWrite MemtoReg IRWrite ALUSrcA
  // RegWrite RegDst ZeroExt | ALUSrcB | ALUOp | PCSource | illegal_op
  logic [17:0] obs_vec;
  assign obs_vec = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead,
                    bus.MemWrite, bus.MemtoReg, bus.IRWrite, bus.ALUSrcA,
                    bus.RegWrite, bus.RegDst, bus.ZeroExt, bus.ALUSrcB,
                    bus.ALUOp, bus.PCSource, bus.illegal_op};

  localparam logic [17:0] V_ZERO     = 18'b00000000000_00_00_00_0;
  localparam logic [17:0] V_FETCH_RD = 18'b10010010000_01_00_00_0;
  localparam logic [17:0] V_FETCH_ST = 18'b00010000000_01_00_00_0;
  localparam logic [17:0] V_DECODE   = 18'b00000000000_11_00_00_0;
  localparam logic [17:0] V_DEC_ILL  = 18'b00000000000_11_00_00_1;
  localparam logic [17:0] V_MEMADR   = 18'b00000001000_10_00_00_0;
  localparam logic [17:0] V_MEMREAD  = 18'b00110000000_00_00_00_0;
  localparam logic [17:0] V_MEMWB    = 18'b00000100100_00_00_00_0;
  localparam logic [17:0] V_MEMWRITE = 18'b00101000000_00_00_00_0;
  localparam logic [17:0] V_EXECUTE  = 18'b00000001000_00_10_00_0;
  localparam logic [17:0] V_RWB      = 18'b00000000110_00_00_00_0;
  localparam logic [17:0] V_BRANCH   = 18'b01000001000_00_01_01_0;
  localparam logic [17:0] V_JUMP     = 18'b10000000000_00_00_10_0;
  localparam logic [17:0] V_IMMEX    = 18'b00000001000_10_00_00_0;
  localparam logic [17:0] V_IMMEX_OR = 18'b00000001001_10_11_00_0;
  localparam logic [17:0] V_IMMWB    = 18'b00000000100_00_00_00_0;

  int n_compared = 0;
  int n_failed   = 0;

  task automatic check(input string tag, input logic [17:0] obs, input logic [17:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_failed++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Checks state code and full output vector for the current cycle.
  task automatic check_cycle(input string tag, input logic [3:0] exp_state,
                             input logic [17:0] exp_vec);
    #1;
    check({tag, ".state"}, {14'd0, bus.state}, {14'd0, exp_state});
    check({tag, ".outs"},  obs_vec, exp_vec);
  endtask

  // Advance one rising edge; inputs may then be changed before check_cycle.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    bus.mem_ready = 1'b1;
    bus.opcode    = 6'b100011;

    // Reset: everything low even though mem_ready is high in FETCH.
    next_cycle();
    check_cycle("reset_hold", 4'd0, V_ZERO);
    reset = 1'b0;
    check_cycle("release_fetch", 4'd0, V_FETCH_RD);

    // lw: 0,1,2,3,4,0
    next_cycle(); check_cycle("lw_decode",  4'd1, V_DECODE);
    next_cycle(); check_cycle("lw_memadr",  4'd2, V_MEMADR);
    next_cycle(); check_cycle("lw_memread", 4'd3, V_MEMREAD);
    next_cycle(); check_cycle("lw_memwb",   4'd4, V_MEMWB);
    next_cycle(); check_cycle("lw_fetch",   4'd0, V_FETCH_RD);

    // R-type with 3 stall cycles in FETCH: 0,0,0,0,1,6,7,0
    bus.opcode    = 6'b000000;
    bus.mem_ready = 1'b0;
    check_cycle("r_stall1", 4'd0, V_FETCH_ST);
    next_cycle(); check_cycle("r_stall2", 4'd0, V_FETCH_ST);
    next_cycle(); check_cycle("r_stall3", 4'd0, V_FETCH_ST);
    next_cycle(); bus.mem_ready = 1'b1;
    check_cycle("r_fetch",   4'd0, V_FETCH_RD);
    next_cycle(); check_cycle("r_decode",  4'd1, V_DECODE);
    next_cycle(); check_cycle("r_execute", 4'd6, V_EXECUTE);
    next_cycle(); check_cycle("r_rwb",     4'd7, V_RWB);
    next_cycle(); check_cycle("r_fetch2",  4'd0, V_FETCH_RD);

    // beq: 0,1,8,0
    bus.opcode = 6'b000100;
    next_cycle(); check_cycle("beq_decode", 4'd1, V_DECODE);
    next_cycle(); check_cycle("beq_branch", 4'd8, V_BRANCH);
    next_cycle(); check_cycle("beq_fetch",  4'd0, V_FETCH_RD);

    // j: 0,1,9,0
    bus.opcode = 6'b000010;
    next_cycle(); check_cycle("j_decode", 4'd1, V_DECODE);
    next_cycle(); check_cycle("j_jump",   4'd9, V_JUMP);
    next_cycle(); check_cycle("j_fetch",  4'd0, V_FETCH_RD);

    // addi: 0,1,10,11,0
    bus.opcode = 6'b001000;
    next_cycle(); check_cycle("addi_decode", 4'd1,  V_DECODE);
    next_cycle(); check_cycle("addi_immex",  4'd10, V_IMMEX);
    next_cycle(); check_cycle("addi_immwb",  4'd11, V_IMMWB);
    next_cycle(); check_cycle("addi_fetch",  4'd0,  V_FETCH_RD);

    // ori: legal only with MC_ORI_EN
    bus.opcode = 6'b001101;
`ifdef MC_ORI_EN
    next_cycle(); check_cycle("ori_decode", 4'd1,  V_DECODE);
    next_cycle(); check_cycle("ori_immex",  4'd10, V_IMMEX_OR);
    next_cycle(); check_cycle("ori_immwb",  4'd11, V_IMMWB);
    next_cycle(); check_cycle("ori_fetch",  4'd0,  V_FETCH_RD);
`else
    next_cycle(); check_cycle("ori_illegal", 4'd1, V_DEC_ILL);
    next_cycle(); check_cycle("ori_fetch",   4'd0, V_FETCH_RD);
`endif

    // Unsupported opcode: one-cycle illegal_op pulse, back to FETCH.
    bus.opcode = 6'b111111;
    next_cycle(); check_cycle("bad_illegal", 4'd1, V_DEC_ILL);
    next_cycle(); check_cycle("bad_fetch",   4'd0, V_FETCH_RD);

    // sw with 2 stall cycles in MEMWRITE: MemWrite held for 3 cycles.
    bus.opcode = 6'b101011;
    next_cycle(); check_cycle("sw_decode", 4'd1, V_DECODE);
    next_cycle(); check_cycle("sw_memadr", 4'd2, V_MEMADR);
    next_cycle(); bus.mem_ready = 1'b0;
    check_cycle("sw_write1", 4'd5, V_MEMWRITE);
    next_cycle(); check_cycle("sw_write2", 4'd5, V_MEMWRITE);
    next_cycle(); bus.mem_ready = 1'b1;
    check_cycle("sw_write3", 4'd5, V_MEMWRITE);
    next_cycle(); check_cycle("sw_fetch",  4'd0, V_FETCH_RD);

    // Reset asserted mid-MEMWRITE with mem_ready low.
    next_cycle(); check_cycle("rst_sw_decode", 4'd1, V_DECODE);
    next_cycle(); check_cycle("rst_sw_memadr", 4'd2, V_MEMADR);
    next_cycle(); bus.mem_ready = 1'b0;
    check_cycle("rst_sw_write", 4'd5, V_MEMWRITE);
    reset = 1'b1;
    check_cycle("rst_async", 4'd0, V_ZERO);
    next_cycle(); check_cycle("rst_held", 4'd0, V_ZERO);
    reset         = 1'b0;
    bus.mem_ready = 1'b1;
    check_cycle("rst_release", 4'd0, V_FETCH_RD);
    next_cycle(); check_cycle("rst_decode", 4'd1, V_DECODE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
